// File: rtl/alu_pkg.sv
// Shared op-codes and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> (result, {n,z,c,v}).
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  // The extra top bit of the difference is the unsigned borrow (a < b).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_SHL:  w_res = i_a << i_b[SHW-1:0];
      OP_SHR:  w_res = i_a >> i_b[SHW-1:0];
      OP_PASS: w_res = i_b;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of a for both ADD and SUB.
    if (w_ovf) begin
      w_res = i_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign o_result       = w_res;
  assign o_flags[FLG_N] = w_res[WIDTH-1];
  assign o_flags[FLG_Z] = (w_res == '0);
  assign o_flags[FLG_C] = w_carry;
  assign o_flags[FLG_V] = w_ovf;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an internal accumulator.
// Saturating ADD/SUB is enabled by defining ALU_SAT_EN (see alu_core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s1_acc_mode;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_g;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_acc;

  logic             w_s2_take;
  logic             w_accept;
  logic             w_move;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;

  assign w_s2_take = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_take;
  assign w_accept  = in_valid && in_ready;
  assign w_move    = r_s1_valid && w_s2_take;

  // Operand A is read from the accumulator at the transfer edge, so chained beats see the previous result.
  assign w_op_a = r_s1_acc_mode ? r_acc : r_s1_a;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (w_op_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // NOTE: stage-1 payload is qualified by r_s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a        <= a;
      r_s1_b        <= b;
      r_s1_op       <= op;
      r_s1_acc_mode <= acc_mode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_g         <= '0;
      r_flags     <= '0;
    end else if (w_s2_take) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_g     <= w_result;
        r_flags <= w_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_move && r_s1_acc_mode) begin
      r_acc <= w_result;
    end
  end

  assign out_valid = r_out_valid;
  assign g         = r_g;
  assign flags     = r_flags;
  assign acc       = r_acc;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH = 8): directed vectors, queued expectations, decoupled monitor.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_mode;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] g;
  logic [3:0] flags;
  logic [7:0] acc;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] g;
    logic [3:0] f;
    string      name;
  } exp_t;

  exp_t sb_q[$];

`ifdef ALU_SAT_EN
  localparam logic [7:0] G_ADD_OVF = 8'h7F;
  localparam logic [3:0] F_ADD_OVF = 4'b0001;
  localparam logic [7:0] G_SUB_OVF = 8'h80;
  localparam logic [3:0] F_SUB_OVF = 4'b1001;
  localparam logic [7:0] G_ADD_NEG = 8'h80;
  localparam logic [3:0] F_ADD_NEG = 4'b1011;
`else
  localparam logic [7:0] G_ADD_OVF = 8'h80;
  localparam logic [3:0] F_ADD_OVF = 4'b1001;
  localparam logic [7:0] G_SUB_OVF = 8'h7F;
  localparam logic [3:0] F_SUB_OVF = 4'b0001;
  localparam logic [7:0] G_ADD_NEG = 8'h00;
  localparam logic [3:0] F_ADD_NEG = 4'b0111;
`endif

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g         (g),
    .flags     (flags),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [7:0] eg, input logic [3:0] ef);
    exp_t e;
    e.g    = eg;
    e.f    = ef;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Offer one beat; it is accepted at the first posedge where in_ready is high.
  task automatic send(input string name, input logic [7:0] ta, input logic [7:0] tb,
                      input logic [2:0] top, input logic tacc,
                      input logic [7:0] eg, input logic [3:0] ef);
    bit ok = 1'b0;
    a        = ta;
    b        = tb;
    op       = top;
    acc_mode = tacc;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s accept: got in_ready=0 for 50 cycles, expected acceptance", name);
    end else begin
      push_exp(name, eg, ef);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got g=0x%0h, expected no output", g);
        end else begin
          e = sb_q.pop_front();
          check({e.name, " g"}, 32'(g), 32'(e.g));
          check({e.name, " flags"}, 32'(flags), 32'(e.f));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_acc;
    int n_seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = OP_ADD;
    acc_mode  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst g", 32'(g), 32'd0);
    check("rst flags", 32'(flags), 32'd0);
    check("rst acc", 32'(acc), 32'd0);
    reset = 1'b1;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);

    // Latency: accepted at edge E0, result valid after E1.
    send("add_7f_01", 8'h7F, 8'h01, OP_ADD, 1'b0, G_ADD_OVF, F_ADD_OVF);
    check("latency s1 out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency s2 out_valid", 32'(out_valid), 32'd1);

    send("sub_03_05",  8'h03, 8'h05, OP_SUB,  1'b0, 8'hFE, 4'b1010);
    send("and_f0_0f",  8'hF0, 8'h0F, OP_AND,  1'b0, 8'h00, 4'b0100);
    send("or_a0_05",   8'hA0, 8'h05, OP_OR,   1'b0, 8'hA5, 4'b1000);
    send("xor_ff_ff",  8'hFF, 8'hFF, OP_XOR,  1'b0, 8'h00, 4'b0100);
    send("shl_81_9",   8'h81, 8'h09, OP_SHL,  1'b0, 8'h02, 4'b0000);
    send("shr_80_7",   8'h80, 8'h07, OP_SHR,  1'b0, 8'h01, 4'b0000);
    send("pass_3c",    8'h12, 8'h3C, OP_PASS, 1'b0, 8'h3C, 4'b0000);
    send("add_ff_01",  8'hFF, 8'h01, OP_ADD,  1'b0, 8'h00, 4'b0110);
    send("add_80_80",  8'h80, 8'h80, OP_ADD,  1'b0, G_ADD_NEG, F_ADD_NEG);
    send("sub_80_01",  8'h80, 8'h01, OP_SUB,  1'b0, G_SUB_OVF, F_SUB_OVF);
    send("sub_05_05",  8'h05, 8'h05, OP_SUB,  1'b0, 8'h00, 4'b0100);
    drain();

    // Accumulator chain: operand A is ignored in acc_mode.
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc after clr", 32'(acc), 32'd0);
    send("acc1", 8'hAA, 8'h10, OP_ADD, 1'b1, 8'h10, 4'b0000);
    send("acc2", 8'hAA, 8'h10, OP_ADD, 1'b1, 8'h20, 4'b0000);
    send("acc3", 8'hAA, 8'h10, OP_ADD, 1'b1, 8'h30, 4'b0000);
    send("acc4", 8'hAA, 8'h10, OP_ADD, 1'b1, 8'h40, 4'b0000);
    drain();
    check("acc chain", 32'(acc), 32'h40);

    // Clear coincides with an acc write: result uses old acc, clear wins.
    send("acc_clr_prio", 8'h00, 8'h01, OP_ADD, 1'b1, 8'h41, 4'b0000);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc clr priority", 32'(acc), 32'd0);
    drain();

    // Stall: continuous offers while the sink refuses for 5 cycles.
    out_ready = 1'b0;
    n_acc     = 0;
    in_valid  = 1'b1;
    op        = OP_PASS;
    acc_mode  = 1'b0;
    a         = 8'h00;
    b         = 8'h11;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp($sformatf("stall_beat%0d", n_acc), b, 4'b0000);
        n_acc++;
      end
      @(posedge clk);
      #1;
      b = 8'(8'h11 + n_acc);
    end
    in_valid = 1'b0;
    check("stall accepted", 32'(n_acc), 32'd2);
    check("stall in_ready", 32'(in_ready), 32'd0);
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall g hold", 32'(g), 32'h11);
    out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = OP_ADD;
    acc_mode  = 1'b1;
    b         = 8'h05;
    @(posedge clk);
    #1;
    acc_mode = 1'b0;
    a        = 8'h01;
    b        = 8'h07;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("inflight out_valid", 32'(out_valid), 32'd1);
    check("inflight acc", 32'(acc), 32'h05);
    reset = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst g", 32'(g), 32'd0);
    check("midrst acc", 32'(acc), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    n_seen    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) n_seen++;
    end
    check("post-reset stale outputs", 32'(n_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, 2-stage pipelined ALU; successor to the registered 4-bit 4-op ALU.
- Adds a WIDTH generic, 8 ops, status flags, an internal accumulator mode and valid/ready handshakes on both sides.
- Sits between an operand source (sequencer or register file) and a result sink; all outputs are registered.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 4).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation code
- acc_mode  in  1  1: operand A := accumulator; result also written to accumulator
- acc_clr  in  1  synchronous accumulator clear
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- g  out  WIDTH  result
- flags  out  4  {n, z, c, v}
- acc  out  WIDTH  current accumulator value

Behaviour:
- Reset (reset = 0, asynchronous): s1_valid, out_valid, g, flags and acc all clear to 0; in_ready is 1 after reset.
- Ops:
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL a<<b[SHW-1:0]
  - 110 SHR (logical) a>>b[SHW-1:0]
  - 111 PASS b
- Stage 1 registers a, b, op and acc_mode on an in_valid && in_ready handshake.
- Compute is combinational from the stage-1 registers; the result and flags load into stage 2 (g/flags) on transfer.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 beat per cycle.
- Handshake:
  - s2_take = !out_valid || out_ready
  - in_ready = !s1_valid || s2_take
  - Stage 1 moves to stage 2 when s1_valid && s2_take.
  - out_valid drops after an out_ready handshake unless a new result loads in the same edge.
  - While stalled (out_valid && !out_ready): g, flags and out_valid hold stable, and in_ready reflects s1_valid.
- Accumulator:
  - When an acc_mode beat transfers to stage 2, its operand A is the acc value at that edge, and acc <= result on the same edge.
  - Back-to-back acc_mode beats chain correctly with no bubble.
- acc_clr:
  - Forces acc to 0 at the next edge; it takes priority over a simultaneous acc write.
  - Beats already in flight see the cleared value only if they transfer after the clear edge.
- Flags:
  - n = result MSB; z = (result == 0).
  - c: ADD carry-out; SUB borrow (a < b unsigned); 0 for all other ops.
  - v: ADD/SUB two's-complement signed overflow; 0 otherwise.
- Results are WIDTH bits and wrap modulo 2^WIDTH (unless ALU_SAT_EN).
- Shift amounts of WIDTH-1 are valid. b bits above SHW are ignored.
- Reset asserted mid-operation discards all in-flight beats; no partial output.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD/SUB saturate in signed terms when v = 1.
  - Positive overflow -> 0111..1; negative overflow -> 1000..0.
  - v still reports the overflow; c is unchanged. The accumulator stores the saturated value.
- Undefined: wrap-around arithmetic only.

Decomposition:
- Package alu_pkg:
  - op-code localparams (OP_ADD .. OP_PASS)
  - flag bit indices (FLG_N = 3, FLG_Z = 2, FLG_C = 1, FLG_V = 0)
- Sub-module alu_core: purely combinational (a, b, op) -> (result, flags), including the saturation logic.
- alu_pipe holds the pipeline registers, handshake and accumulator.

Test Plan (all with WIDTH = 8):
- Reset, then ADD 0x7F+0x01, out_ready = 1 -> out_valid 2 cycles later; g = 0x80, flags n=1 z=0 c=0 v=1 (with ALU_SAT_EN: g = 0x7F, v = 1).
- SUB 0x03-0x05 -> g = 0xFE, c = 1, n = 1. AND 0xF0&0x0F -> g = 0x00, z = 1.
- acc_clr, then 4 back-to-back acc_mode ADD beats with b = 0x10 -> results 0x10, 0x20, 0x30, 0x40 on consecutive cycles; acc = 0x40.
- out_ready = 0 for 5 cycles with a continuous in_valid stream -> exactly 2 beats accepted, then in_ready = 0; g stable; on release, results emerge in order with none lost or duplicated.
- SHL 0x81 by b = 0x09 (amount 1) -> g = 0x02. SHR 0x80 by 7 -> g = 0x01.
- Assert reset while 2 beats are in flight -> out_valid, g and acc are 0 immediately; no stale result after reset releases.
